// File: rtl/bcd_pkg.sv
// Shared types and helpers for the chunked BCD adder sequencer.
// Holds the digit width, digit range check and FSM state encoding.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    function automatic logic digit_is_valid(input logic [BCD_DIGIT_W-1:0] d);
        return d <= BCD_DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_chunk_add_sequencer_if.sv
// Requester-side handshake and operand/result bundle for the BCD sequencer.
// The requester drives the master side; the sequencer owns the slave side.
interface bcd_chunk_add_sequencer_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int CHUNKS = 4
);
    localparam int W = BCD_DIGIT_W * DIGITS * CHUNKS;

    logic         start;
    logic         cin;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;

    modport master (
        output start, cin, A, B,
        input  ready, busy, done, sum, cout, invalid
    );

    modport slave (
        input  start, cin, A, B,
        output ready, busy, done, sum, cout, invalid
    );

endinterface

// File: rtl/bcd_chunk_adder.sv
// Combinational DIGITS-digit BCD adder; the one datapath stage the
// sequencer reuses for every chunk.
module bcd_chunk_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                          cin,
    output logic [BCD_DIGIT_W*DIGITS-1:0] s,
    output logic                          cout
);

    logic [BCD_DIGIT_W:0] t;
    logic                 c;

    always_comb begin
        s = '0;
        t = '0;
        c = cin;
        for (int i = 0; i < DIGITS; i++) begin
            t = {1'b0, a[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
              + {1'b0, b[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
              + {{BCD_DIGIT_W{1'b0}}, c};
            // Adding 6 skips the six unused nibble codes 10..15.
            if (t > (BCD_DIGIT_W+1)'(BCD_MAX)) begin
                s[i*BCD_DIGIT_W +: BCD_DIGIT_W] = t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(6);
                c = 1'b1;
            end else begin
                s[i*BCD_DIGIT_W +: BCD_DIGIT_W] = t[BCD_DIGIT_W-1:0];
                c = 1'b0;
            end
        end
        cout = c;
    end

endmodule

// File: rtl/bcd_chunk_add_sequencer.sv
// Adds two wide BCD words one chunk per clock, LS chunk first, through a
// single shared bcd_chunk_adder with the decimal carry held in a register.
module bcd_chunk_add_sequencer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int CHUNKS = 4
) (
    input logic                       clk,
    input logic                       rst,
    bcd_chunk_add_sequencer_if.slave  bus
);

    localparam int CW = BCD_DIGIT_W * DIGITS;
    localparam int W  = CW * CHUNKS;
    localparam int ND = DIGITS * CHUNKS;
    localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           inv_q, inv_d;

    logic [CW-1:0]  a_ch, b_ch, s_ch;
    logic           c_ch;
    logic           ops_ok;

    always_comb begin
        ops_ok = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (!digit_is_valid(bus.A[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                !digit_is_valid(bus.B[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
                ops_ok = 1'b0;
        end
    end

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            if (idx_q == IW'(k)) begin
                a_ch = a_q[k*CW +: CW];
                b_ch = b_q[k*CW +: CW];
            end
        end
    end

    bcd_chunk_adder #(.DIGITS(DIGITS)) u_add (
        .a    (a_ch),
        .b    (b_ch),
        .cin  (carry_q),
        .s    (s_ch),
        .cout (c_ch)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        inv_d   = inv_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    inv_d   = !ops_ok;
                    state_d = ops_ok ? S_ADD : S_FIN;
                end
            end
            S_ADD: begin
                for (int k = 0; k < CHUNKS; k++) begin
                    if (idx_q == IW'(k))
                        sum_d[k*CW +: CW] = s_ch;
                end
                carry_d = c_ch;
                if (idx_q == IW'(CHUNKS-1)) begin
                    cout_d  = c_ch;
                    state_d = S_FIN;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            inv_q   <= inv_d;
        end
    end

    assign bus.ready   = (state_q == S_IDLE);
    assign bus.busy    = (state_q == S_ADD);
    assign bus.done    = (state_q == S_FIN);
    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
    assign bus.invalid = inv_q;

endmodule

// File: tb/tb_bcd_chunk_add_sequencer.sv
// Directed-vector and decimal-model bench for bcd_chunk_add_sequencer.
// Latency is counted in clock edges after the accept edge.
module tb_bcd_chunk_add_sequencer;

    localparam int DIGITS = 3;
    localparam int CHUNKS = 4;
    localparam int ND     = DIGITS * CHUNKS;
    localparam int W      = 4 * ND;

    logic clk;
    logic rst;

    bcd_chunk_add_sequencer_if #(.DIGITS(DIGITS), .CHUNKS(CHUNKS)) bus ();

    bcd_chunk_add_sequencer #(.DIGITS(DIGITS), .CHUNKS(CHUNKS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         inv;
        int           lat;
        int           bcnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic longint unsigned from_bcd(input logic [W-1:0] v);
        longint unsigned r = 0;
        for (int i = ND-1; i >= 0; i--)
            r = r * 10 + longint'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint unsigned v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, output int lat, output int bc,
                          output logic [W-1:0] s, output logic co,
                          output logic inv);
        @(negedge clk);
        chk("ready_before_start", 64'(bus.ready), 64'd1);
        bus.A = a; bus.B = b; bus.cin = ci; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A = '0; bus.B = '0; bus.cin = 1'b0;
        lat = 0;
        bc  = 0;
        while (lat <= 20) begin
            @(negedge clk);
            if (bus.done) break;
            if (bus.busy) bc++;
            @(posedge clk);
            lat++;
        end
        s   = bus.sum;
        co  = bus.cout;
        inv = bus.invalid;
    endtask

    int           lat, bc, pulses;
    logic [W-1:0] s, held;
    logic         co, inv, seen;

    initial begin
        tbl[0] = '{48'h999999999999, 48'h000000000001, 1'b0,
                   48'h000000000000, 1'b1, 1'b0, 4, 4};
        tbl[1] = '{48'h123456789012, 48'h987654321098, 1'b1,
                   48'h111111110111, 1'b1, 1'b0, 4, 4};
        tbl[2] = '{48'h00000000000A, 48'h000000000001, 1'b0,
                   48'h000000000000, 1'b0, 1'b1, 0, 0};
        tbl[3] = '{48'h000000000123, 48'h000000000456, 1'b0,
                   48'h000000000579, 1'b0, 1'b0, 4, 4};
        tbl[4] = '{48'h500000000000, 48'h500000000000, 1'b1,
                   48'h000000000001, 1'b1, 1'b0, 4, 4};
        tbl[5] = '{48'h000000000999, 48'h000000000001, 1'b0,
                   48'h000000001000, 1'b0, 1'b0, 4, 4};
        tbl[6] = '{48'h000000000001, 48'hF00000000000, 1'b1,
                   48'h000000000000, 1'b0, 1'b1, 0, 0};
        tbl[7] = '{48'h000000000000, 48'h000000000000, 1'b1,
                   48'h000000000001, 1'b0, 1'b0, 4, 4};

        rst = 1'b1;
        bus.start = 1'b0; bus.cin = 1'b0; bus.A = '0; bus.B = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
        chk("rst_invalid", 64'(bus.invalid), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].ci, lat, bc, s, co, inv);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(tbl[i].bcnt));
            chk($sformatf("v%0d_sum", i), 64'(s), 64'(tbl[i].s));
            chk($sformatf("v%0d_cout", i), 64'(co), 64'(tbl[i].co));
            chk($sformatf("v%0d_invalid", i), 64'(inv), 64'(tbl[i].inv));
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), 64'(bus.done), 64'd0);
            chk($sformatf("v%0d_ready_after", i), 64'(bus.ready), 64'd1);
            chk($sformatf("v%0d_sum_held", i), 64'(bus.sum), 64'(tbl[i].s));
        end

        // Abort an addition with reset part way through.
        @(negedge clk);
        bus.A = 48'h000000000123; bus.B = 48'h000000000456; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_pre", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_ready", 64'(bus.ready), 64'd1);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_sum", 64'(bus.sum), 64'd0);
        chk("abort_cout", 64'(bus.cout), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        bus.A = 48'h999999999999; bus.B = 48'h000000000001;
        bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        bus.A = 48'h555555555555; bus.B = 48'h555555555555; bus.start = 1'b1;
        pulses = 0;
        held = '1;
        co = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                held = bus.sum;
                co = bus.cout;
                bus.start = 1'b0;
                @(negedge clk);
                chk("ign_ready_after_fin", 64'(bus.ready), 64'd1);
            end
        end
        bus.start = 1'b0;
        chk("ign_pulses", 64'(pulses), 64'd1);
        chk("ign_sum", 64'(held), 64'd0);
        chk("ign_cout", 64'(co), 64'd1);

        // Start held high: next operation taken on the first IDLE edge.
        @(negedge clk);
        bus.A = 48'h000000000001; bus.B = 48'h000000000002;
        bus.cin = 1'b0; bus.start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("b2b_first_done", 64'(seen), 64'd1);
        chk("b2b_first_sum", 64'(bus.sum), 64'h3);
        @(negedge clk);
        chk("b2b_idle_ready", 64'(bus.ready), 64'd1);
        bus.A = 48'h000000000004; bus.B = 48'h000000000005;
        @(negedge clk);
        chk("b2b_second_busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("b2b_second_done", 64'(seen), 64'd1);
        chk("b2b_second_sum", 64'(bus.sum), 64'h9);

        // Random valid operands against a decimal reference.
        for (int n = 0; n < 200; n++) begin
            logic [W-1:0]    ra, rb, es;
            logic            rc, ec;
            longint unsigned tot;
            for (int d = 0; d < ND; d++) begin
                ra[d*4 +: 4] = 4'($urandom_range(0, 9));
                rb[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            rc  = 1'($urandom_range(0, 1));
            tot = from_bcd(ra) + from_bcd(rb) + longint'(rc);
            es  = to_bcd(tot % 64'd1000000000000);
            ec  = (tot >= 64'd1000000000000);
            run_op(ra, rb, rc, lat, bc, s, co, inv);
            chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'(CHUNKS));
            chk($sformatf("rnd%0d_sum", n), 64'(s), 64'(es));
            chk($sformatf("rnd%0d_cout", n), 64'(co), 64'(ec));
            chk($sformatf("rnd%0d_inv", n), 64'(inv), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
